alu_cmd_issuer: RTL and testbench
=================================

# alu_cmd_issuer

Initiator for the ALU's PStart/PDone handshake. It accepts operation commands from an upstream valid/ready port and drives opcode and operands into the ALU, then pulses PStart and waits for PDone. When PDone arrives it captures result and extra_result and presents them on a downstream valid/ready response port. It sits between the instruction-decode stage and the ALU, replacing direct combinational drive of the ALU inputs.

## Interface
- TIMEOUT, 64, number of cycles to wait for PDone before aborting (only used with ALU_TIMEOUT_EN); minimum 2
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- cmd_valid  in  1  upstream command valid
- cmd_ready  out  1  issuer can accept a command
- cmd_opcode  in  3  ALU opcode
- cmd_a  in  32  operand A
- cmd_b  in  32  operand B
- alu_opcode  out  3  to ALU opcode
- alu_inA  out  32  to ALU inA
- alu_inB  out  32  to ALU inB
- alu_PStart  out  1  start pulse to ALU
- alu_PDone  in  1  completion pulse from ALU
- alu_result  in  32  ALU result
- alu_extra  in  32  ALU extra_result (MUL high word)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  downstream accepts response
- rsp_opcode  out  3  opcode of the completed command
- rsp_result  out  32  captured result
- rsp_extra  out  32  captured extra_result
- rsp_err  out  1  response produced by timeout
- ops_issued  out  16  count of PStart pulses, wraps at 0xFFFF->0

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid, latch opcode/a/b into the ALU-drive registers and go to START.
- START: alu_PStart=1 for exactly this cycle, ops_issued increments, then go to WAIT.
- WAIT: alu_PStart=0, and operands stay stable. On alu_PDone=1, capture alu_result, alu_extra and opcode into the rsp registers, clear rsp_err, and go to RESP.
- RESP: rsp_valid=1. On rsp_ready, go to IDLE.
- cmd_ready=0 in every state except IDLE. Only one command is in flight.
- alu_PDone is ignored in IDLE, START and RESP. A stale PDone must not create a response.
- Operands and opcode are held unchanged from START until the FSM leaves WAIT, and are not cleared on return to IDLE.
- No arithmetic is performed here. Results pass through bit-exact.

## Timing
- Reset values: cmd_ready=0 during reset and 1 from the first cycle after deassertion; alu_PStart=0; alu_opcode/inA/inB=0; rsp_valid=0; rsp_opcode/result/extra=0; rsp_err=0; ops_issued=0; state IDLE.
- Accept cycle N (cmd_valid & cmd_ready). alu_PStart is high in cycle N+1. PDone is sampled from N+2 onward.
- PDone in cycle M gives rsp_valid=1 from cycle M+1. Minimum command-to-response latency is 3 cycles.
- A response is held stable while rsp_valid & !rsp_ready.
- The next command can be accepted in the cycle after the rsp handshake.
- Asserting rst_n mid-operation (any state) immediately returns the block to IDLE with all outputs at reset values. An in-flight response is dropped, and a later PDone is ignored.

## Configuration
- ALU_TIMEOUT_EN defined:
  - A cycle counter runs in WAIT, starting at 0 on WAIT entry.
  - If the counter reaches TIMEOUT-1 without PDone, the FSM goes to RESP with rsp_err=1 and rsp_result=rsp_extra=0.
  - PDone in the same cycle as expiry wins: normal response, rsp_err=0.
- ALU_TIMEOUT_EN undefined:
  - There is no counter and WAIT is exited only by PDone.
  - rsp_err is tied to 0 and TIMEOUT is unused.

## Structure
- Shared package alu_pkg holds:
  - opcode constants ADD=000, SUB=001, OR=010, AND=011, NOT=100, MUL=101, SLL=110, SLR=111
  - the issuer state encoding
  - the 32-bit data width constant
- This block and the ALU both import alu_pkg.
- No sub-module. The FSM, timeout counter and ops counter are inline.

## Test plan
- ADD, a=1256, b=1453, ALU model with 1-cycle PDone:
  - rsp_result=2709, rsp_opcode=000, rsp_err=0.
  - Response appears 3 cycles after accept.
  - ops_issued=1.
- MUL, a=2018, b=1997, PDone delayed 8 cycles:
  - rsp_result=4029946, rsp_extra=0.
  - alu_inA/inB stable for the full wait.
  - PStart high exactly one cycle.
- SUB, a=10, b=20, with rsp_ready held low 5 cycles:
  - rsp_result=0xFFFFFFF6 held stable.
  - cmd_ready stays 0 until the handshake.
- Spurious PDone pulse in IDLE, then an OR command with a=10, b=20:
  - No response from the stray pulse.
  - Exactly one response with result 30.
- rst_n asserted during WAIT of a MUL, then the ALU model's late PDone:
  - All outputs reset and no rsp_valid.
  - The next ADD with a=0xFFFFFFFF, b=20 returns 19.
- With ALU_TIMEOUT_EN and TIMEOUT=16, ALU model never asserts PDone:
  - rsp_valid rises 16 cycles after PStart, with rsp_err=1 and rsp_result=0.
  - Repeat with PDone in the expiry cycle: rsp_err=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, opcode encodings and the command issuer FSM encoding.
// Both the ALU and alu_cmd_issuer import this package.
package alu_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned OpW   = 3;

  localparam logic [OpW-1:0] OpAdd = 3'b000;
  localparam logic [OpW-1:0] OpSub = 3'b001;
  localparam logic [OpW-1:0] OpOr  = 3'b010;
  localparam logic [OpW-1:0] OpAnd = 3'b011;
  localparam logic [OpW-1:0] OpNot = 3'b100;
  localparam logic [OpW-1:0] OpMul = 3'b101;
  localparam logic [OpW-1:0] OpSll = 3'b110;
  localparam logic [OpW-1:0] OpSlr = 3'b111;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StWait,
    StResp
  } issuer_state_e;

endpackage

// File: rtl/alu_cmd_issuer.sv
// Issues one command at a time to the ALU over PStart/PDone and returns the captured result on a
// valid/ready response port. Define ALU_TIMEOUT_EN to abort a wait after TIMEOUT cycles.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OpW-1:0]   cmd_opcode,
  input  logic [DataW-1:0] cmd_a,
  input  logic [DataW-1:0] cmd_b,
  output logic [OpW-1:0]   alu_opcode,
  output logic [DataW-1:0] alu_inA,
  output logic [DataW-1:0] alu_inB,
  output logic             alu_PStart,
  input  logic             alu_PDone,
  input  logic [DataW-1:0] alu_result,
  input  logic [DataW-1:0] alu_extra,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [OpW-1:0]   rsp_opcode,
  output logic [DataW-1:0] rsp_result,
  output logic [DataW-1:0] rsp_extra,
  output logic             rsp_err,
  output logic [15:0]      ops_issued
);

  if (TIMEOUT < 2) begin : g_timeout_check
    $error("alu_cmd_issuer: TIMEOUT must be at least 2");
  end

  issuer_state_e    state_q;
  logic             cmd_ready_q;
  logic             pstart_q;
  logic [OpW-1:0]   op_q;
  logic [DataW-1:0] a_q;
  logic [DataW-1:0] b_q;
  logic             rsp_valid_q;
  logic [OpW-1:0]   rsp_op_q;
  logic [DataW-1:0] rsp_res_q;
  logic [DataW-1:0] rsp_ext_q;
  logic [15:0]      ops_q;

`ifdef ALU_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  // Expire on the edge where the counter would reach TIMEOUT-1.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 2);

  logic [CntW-1:0] wait_cnt_q;
  logic            rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b0;
      pstart_q    <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_res_q   <= '0;
      rsp_ext_q   <= '0;
      ops_q       <= '0;
`ifdef ALU_TIMEOUT_EN
      wait_cnt_q  <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_opcode;
            a_q         <= cmd_a;
            b_q         <= cmd_b;
            pstart_q    <= 1'b1;
            cmd_ready_q <= 1'b0;
            state_q     <= StStart;
          end
        end
        StStart: begin
          pstart_q <= 1'b0;
          ops_q    <= ops_q + 16'd1;
          state_q  <= StWait;
`ifdef ALU_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        StWait: begin
          if (alu_PDone) begin
            rsp_op_q    <= op_q;
            rsp_res_q   <= alu_result;
            rsp_ext_q   <= alu_extra;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
`ifdef ALU_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (wait_cnt_q == CntLast) begin
            rsp_op_q    <= op_q;
            rsp_res_q   <= '0;
            rsp_ext_q   <= '0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            wait_cnt_q  <= wait_cnt_q + CntW'(1);
`endif
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign alu_PStart = pstart_q;
  assign alu_opcode = op_q;
  assign alu_inA    = a_q;
  assign alu_inB    = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_opcode = rsp_op_q;
  assign rsp_result = rsp_res_q;
  assign rsp_extra  = rsp_ext_q;
  assign ops_issued = ops_q;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: directed cases and randomized traffic checked every cycle against a
// timestamp-based model of the command/response handshake. Timeout cases need ALU_TIMEOUT_EN.
module tb_alu_cmd_issuer;
  import alu_pkg::*;

  localparam int unsigned To = 16;
`ifdef ALU_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_opcode;
  logic [31:0] cmd_a, cmd_b;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_inA, alu_inB;
  logic        alu_PStart, alu_PDone;
  logic [31:0] alu_result, alu_extra;
  logic        rsp_valid, rsp_ready;
  logic [2:0]  rsp_opcode;
  logic [31:0] rsp_result, rsp_extra;
  logic        rsp_err;
  logic [15:0] ops_issued;

  logic resp_pdone, stray_pdone, dir_stray;
  logic rand_en, rand_ready, dir_ready, stray_en;
  assign alu_PDone = resp_pdone | stray_pdone | dir_stray;
  assign rsp_ready = rand_en ? rand_ready : dir_ready;

  int n_chk = 0, n_pass = 0, n_hs = 0;
  bit saw_valid = 1'b0;
  int dly_q[$];

  // Model: times are posedge indices; a command accepted at edge p has PStart in cycle p.
  int          m_cyc = 0, m_acc = 0;
  bit          m_busy, m_rsp_pend, m_ready;
  logic [2:0]  m_op, m_rsp_op;
  logic [31:0] m_a, m_b, m_rsp_res, m_rsp_ext;
  logic        m_rsp_err;
  logic [15:0] m_ops;

  alu_cmd_issuer #(.TIMEOUT(To)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .alu_opcode(alu_opcode),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_PStart(alu_PStart), .alu_PDone(alu_PDone),
    .alu_result(alu_result), .alu_extra(alu_extra), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_opcode(rsp_opcode), .rsp_result(rsp_result),
    .rsp_extra(rsp_extra), .rsp_err(rsp_err), .ops_issued(ops_issued)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    case (op)
      OpAdd: r[31:0] = a + b;
      OpSub: r[31:0] = a - b;
      OpOr:  r[31:0] = a | b;
      OpAnd: r[31:0] = a & b;
      OpNot: r[31:0] = ~a;
      OpMul: r = {32'b0, a} * {32'b0, b};
      OpSll: r[31:0] = a << b[4:0];
      OpSlr: r[31:0] = a >> b[4:0];
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic m_reset();
    m_busy = 0; m_rsp_pend = 0; m_ready = 0;
    m_op = '0; m_a = '0; m_b = '0; m_ops = '0;
    m_rsp_op = '0; m_rsp_res = '0; m_rsp_ext = '0; m_rsp_err = 1'b0;
  endtask

  task automatic m_step();
    m_cyc++;
    if (m_busy && m_rsp_pend) begin
      if (rsp_ready) begin m_busy = 0; m_rsp_pend = 0; end
    end else if (m_busy) begin
      if (m_cyc == m_acc + 1) m_ops++;
      else if (alu_PDone) begin
        {m_rsp_ext, m_rsp_res} = alu_ref(m_op, m_a, m_b);
        m_rsp_op = m_op; m_rsp_err = 1'b0; m_rsp_pend = 1;
      end else if (ToEn && m_cyc == m_acc + int'(To)) begin
        m_rsp_ext = '0; m_rsp_res = '0;
        m_rsp_op = m_op; m_rsp_err = 1'b1; m_rsp_pend = 1;
      end
    end else if (cmd_valid && m_ready) begin
      m_busy = 1; m_acc = m_cyc;
      m_op = cmd_opcode; m_a = cmd_a; m_b = cmd_b;
    end
    m_ready = !m_busy;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("cmd_ready", {31'b0, cmd_ready}, {31'b0, m_ready});
      chk("alu_PStart", {31'b0, alu_PStart}, {31'b0, m_busy && (m_cyc == m_acc)});
      chk("alu_opcode", {29'b0, alu_opcode}, {29'b0, m_op});
      chk("alu_inA", alu_inA, m_a);
      chk("alu_inB", alu_inB, m_b);
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, m_rsp_pend});
      chk("rsp_opcode", {29'b0, rsp_opcode}, {29'b0, m_rsp_op});
      chk("rsp_result", rsp_result, m_rsp_res);
      chk("rsp_extra", rsp_extra, m_rsp_ext);
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, m_rsp_err});
      chk("ops_issued", {16'b0, ops_issued}, {16'b0, m_ops});
      if (rsp_valid && rsp_ready) n_hs++;
      if (rsp_valid) saw_valid = 1'b1;
    end
  end

  // ALU stand-in: PDone d cycles after PStart (never if d < 0), garbage result otherwise.
  initial begin
    int d;
    logic [63:0] r;
    resp_pdone = 1'b0; alu_result = '0; alu_extra = '0;
    forever begin
      @(posedge clk); #1;
      alu_result = $urandom; alu_extra = $urandom;
      if (alu_PStart && dly_q.size() > 0) begin
        d = dly_q.pop_front();
        if (d >= 0) begin
          repeat (d) begin @(posedge clk); #1; alu_result = $urandom; alu_extra = $urandom; end
          r = alu_ref(alu_opcode, alu_inA, alu_inB);
          resp_pdone = 1'b1; {alu_extra, alu_result} = r;
          @(posedge clk); #1;
          resp_pdone = 1'b0; alu_result = $urandom; alu_extra = $urandom;
        end
      end
    end
  end

  initial begin
    rand_ready = 1'b0; stray_pdone = 1'b0;
    forever begin
      @(posedge clk); #1;
      rand_ready = ($urandom_range(0, 2) != 0);
      stray_pdone = stray_en && (!m_busy || m_rsp_pend) && ($urandom_range(0, 5) == 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic send_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int d);
    bit ok = 1'b0;
    dly_q.push_back(d);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_opcode = 3'($urandom); cmd_a = $urandom; cmd_b = $urandom;
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      void'(dly_q.pop_back());
    end
  endtask

  // Counts negedges until rsp_valid is seen.
  task automatic wait_rsp(output int t);
    t = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); t++;
      if (rsp_valid) return;
    end
    chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (cmd_ready) begin @(posedge clk); #1; return; end
    end
    chk("idle_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_pstart();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (alu_PStart) return;
    end
    chk("pstart_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t, pst, hs0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0;
    dir_ready = 1'b1; rand_en = 1'b0; stray_en = 1'b0; dir_stray = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("reset ops_issued", {16'b0, ops_issued}, 32'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD with 1-cycle PDone: response 3 cycles after the accept cycle
    send_cmd(OpAdd, 32'd1256, 32'd1453, 1);
    wait_rsp(t);
    chk("add latency", t, 32'd3);
    chk("add result", rsp_result, 32'd2709);
    chk("add opcode", {29'b0, rsp_opcode}, 32'd0);
    chk("add err", {31'b0, rsp_err}, 32'd0);
    chk("add ops_issued", {16'b0, ops_issued}, 32'd1);
    wait_idle();

    // MUL with PDone 8 cycles after PStart
    send_cmd(OpMul, 32'd2018, 32'd1997, 8);
    pst = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      if (alu_PStart) pst++;
      chk("mul inA stable", alu_inA, 32'd2018);
      chk("mul inB stable", alu_inB, 32'd1997);
    end
    chk("mul pstart cycles", pst, 32'd1);
    chk("mul result", rsp_result, 32'd4029946);
    chk("mul extra", rsp_extra, 32'd0);
    wait_idle();

    // SUB with the response held off for 5 cycles
    dir_ready = 1'b0;
    send_cmd(OpSub, 32'd10, 32'd20, 2);
    wait_rsp(t);
    for (int i = 0; i < 5; i++) begin
      chk("sub held result", rsp_result, 32'hFFFF_FFF6);
      chk("sub held valid", {31'b0, rsp_valid}, 32'd1);
      chk("sub cmd_ready low", {31'b0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1 dir_ready = 1'b1;
    wait_idle();

    // Stray PDone in IDLE, then OR
    hs0 = n_hs; saw_valid = 1'b0;
    dir_stray = 1'b1;
    @(posedge clk); #1 dir_stray = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("stray no rsp", {31'b0, saw_valid}, 32'd0);
    send_cmd(OpOr, 32'd10, 32'd20, 3);
    wait_rsp(t);
    chk("or result", rsp_result, 32'd30);
    wait_idle();
    repeat (3) @(posedge clk); #1;
    chk("or one response", n_hs - hs0, 32'd1);

    // Reset during WAIT of a MUL; its late PDone must be ignored
    send_cmd(OpMul, 32'd7, 32'd9, 8);
    wait_pstart();
    repeat (3) @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("midrst inA", alu_inA, 32'd0);
    chk("midrst opcode", {29'b0, alu_opcode}, 32'd0);
    chk("midrst ops", {16'b0, ops_issued}, 32'd0);
    chk("midrst cmd_ready", {31'b0, cmd_ready}, 32'd0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("late pdone no rsp", {31'b0, saw_valid}, 32'd0);
    send_cmd(OpAdd, 32'hFFFF_FFFF, 32'd20, 1);
    wait_rsp(t);
    chk("add wrap result", rsp_result, 32'd19);
    chk("add wrap ops", {16'b0, ops_issued}, 32'd1);
    wait_idle();

`ifdef ALU_TIMEOUT_EN
    // No PDone: response TIMEOUT cycles after PStart with rsp_err set
    send_cmd(OpMul, 32'd3, 32'd4, -1);
    wait_pstart();
    wait_rsp(t);
    chk("timeout latency", t, To);
    chk("timeout err", {31'b0, rsp_err}, 32'd1);
    chk("timeout result", rsp_result, 32'd0);
    wait_idle();
    // PDone in the expiry cycle wins
    send_cmd(OpAdd, 32'd5, 32'd6, To - 1);
    wait_pstart();
    wait_rsp(t);
    chk("expiry pdone latency", t, To);
    chk("expiry pdone err", {31'b0, rsp_err}, 32'd0);
    chk("expiry pdone result", rsp_result, 32'd11);
    wait_idle();
`endif

    // Randomized traffic with back-to-back commands, random backpressure and stray pulses
    rand_en = 1'b1; stray_en = 1'b1;
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      send_cmd(3'($urandom_range(0, 7)), a, b, $urandom_range(1, 10));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    for (int i = 0; i < 400 && m_busy; i++) @(posedge clk);
    #1;
    chk("drain idle", {31'b0, m_busy}, 32'd0);
    stray_en = 1'b0; rand_en = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
